sysid_boot_checker: RTL

- Avalon-MM master that sequences the system-ID slave after reset or on request.
- Reads the ID word at address 0, then the timestamp word at address 1, and compares both against build-time expected values.
- Retries on mismatch and reports a sticky pass/fail verdict to boot logic, the CPU reset hold-off, and LEDs.
- Sits between the sysid slave's control port and system bring-up logic.

---
 rtl/sysid_boot_checker.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/sysid_boot_checker.sv
// rtl/sysid_boot_checker.sv - Avalon-MM master that reads and verifies the sysid words at boot
// Optional periodic re-check is built when SYSID_PERIODIC_CHECK_EN is defined.
module sysid_boot_checker #(
  parameter logic [31:0] EXPECTED_ID  = 32'd0,
  parameter logic [31:0] EXPECTED_TS  = 32'd1453660413,
  parameter int          READ_LATENCY = 0,
  parameter int          MAX_RETRIES  = 3,
  parameter bit          AUTO_START   = 1'b1
`ifdef SYSID_PERIODIC_CHECK_EN
  ,
  parameter logic [31:0] RECHECK_PERIOD = 32'd1000000
`endif
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        sys_ok,
  output logic        id_match,
  output logic        ts_match,
  output logic [31:0] captured_id,
  output logic [31:0] captured_ts,
  output logic [3:0]  attempts
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_ID   = 3'd1;
  localparam logic [2:0] S_WAIT_ID = 3'd2;
  localparam logic [2:0] S_RD_TS   = 3'd3;
  localparam logic [2:0] S_WAIT_TS = 3'd4;
  localparam logic [2:0] S_CHECK   = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  localparam logic [1:0] LAT_LAST    = 2'(READ_LATENCY > 0 ? READ_LATENCY - 1 : 0);
  localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRIES);

  logic [2:0] state;
  logic       auto_pending;
  logic [1:0] lat_cnt;
  logic       recheck_hit;
  logic       launch;
  logic       id_ok;
  logic       ts_ok;

`ifdef SYSID_PERIODIC_CHECK_EN
  logic [31:0] period_cnt;

  // Held at zero outside DONE, so it effectively reloads on every DONE entry.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      period_cnt <= 32'd0;
    end else if (state != S_DONE) begin
      period_cnt <= 32'd0;
    end else begin
      period_cnt <= period_cnt + 32'd1;
    end
  end

  assign recheck_hit = (state == S_DONE) && (period_cnt == RECHECK_PERIOD - 32'd1);
`else
  assign recheck_hit = 1'b0;
`endif

  assign launch      = ((state == S_IDLE) || (state == S_DONE)) && (start || auto_pending || recheck_hit);
  assign id_ok       = (captured_id == EXPECTED_ID);
  assign ts_ok       = (captured_ts == EXPECTED_TS);
  assign avm_read    = (state == S_RD_ID) || (state == S_RD_TS);
  assign avm_address = (state == S_RD_TS) || (state == S_WAIT_TS);
  assign busy        = (state != S_IDLE) && (state != S_DONE);
  assign done        = (state == S_DONE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      auto_pending <= AUTO_START;
      lat_cnt      <= 2'd0;
      sys_ok       <= 1'b0;
      id_match     <= 1'b0;
      ts_match     <= 1'b0;
      captured_id  <= 32'd0;
      captured_ts  <= 32'd0;
      attempts     <= 4'd0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (launch) begin
            state        <= S_RD_ID;
            auto_pending <= 1'b0;
            sys_ok       <= 1'b0;
            id_match     <= 1'b0;
            ts_match     <= 1'b0;
            attempts     <= 4'd1;
          end
        end
        S_RD_ID: begin
          if (!avm_waitrequest) begin
            lat_cnt <= 2'd0;
            if (READ_LATENCY == 0) begin
              captured_id <= avm_readdata;
              state       <= S_RD_TS;
            end else begin
              state <= S_WAIT_ID;
            end
          end
        end
        S_WAIT_ID: begin
          if (lat_cnt == LAT_LAST) begin
            captured_id <= avm_readdata;
            state       <= S_RD_TS;
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end
        S_RD_TS: begin
          if (!avm_waitrequest) begin
            lat_cnt <= 2'd0;
            if (READ_LATENCY == 0) begin
              captured_ts <= avm_readdata;
              state       <= S_CHECK;
            end else begin
              state <= S_WAIT_TS;
            end
          end
        end
        S_WAIT_TS: begin
          if (lat_cnt == LAT_LAST) begin
            captured_ts <= avm_readdata;
            state       <= S_CHECK;
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end
        S_CHECK: begin
          id_match <= id_ok;
          ts_match <= ts_ok;
          if (id_ok && ts_ok) begin
            sys_ok <= 1'b1;
            state  <= S_DONE;
          end else if (attempts <= RETRY_LIMIT) begin
            attempts <= (attempts == 4'd15) ? attempts : attempts + 4'd1;
            state    <= S_RD_ID;
          end else begin
            state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
